// File: rtl/mips_store_checker.sv
// Store checker for the MIPS data-memory write port: compares each committed store,
// in order, against a loaded table of expected (address, data) pairs.
module mips_store_checker #(
    parameter  int NUM_EXP        = 8,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int IW             = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int CW             = $clog2(NUM_EXP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [31:0]   exp_addr,
    input  logic [31:0]   exp_data,
    input  logic [CW-1:0] exp_count,
    input  logic          start,
    input  logic          memwrite,
    input  logic [31:0]   aluout,
    input  logic [31:0]   writedata,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic          timeout,
    output logic [CW-1:0] store_count,
    output logic [31:0]   err_addr,
    output logic [31:0]   err_data
);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] CYC_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] CYC_MAX   = '1;
    localparam logic [CW-1:0] NUM_EXP_C = CW'(NUM_EXP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        r_state,       w_state_nxt;
    logic [CW-1:0] r_exp_cnt,     w_exp_cnt_nxt;
    logic [CW-1:0] r_store_count, w_store_count_nxt;
    logic [TW-1:0] r_cyc,         w_cyc_nxt;
    logic          r_timeout,     w_timeout_nxt;
    logic [31:0]   r_err_addr,    w_err_addr_nxt;
    logic [31:0]   r_err_data,    w_err_data_nxt;

    logic [63:0]   r_table [NUM_EXP];
    logic [63:0]   w_exp_entry;
    logic [CW-1:0] w_count_inc;
    logic [CW-1:0] w_cnt_clamped;
    logic          w_hit;

    assign w_cnt_clamped = (exp_count > NUM_EXP_C) ? NUM_EXP_C : exp_count;
    assign w_count_inc   = r_store_count + CW'(1);

    // store_count never reaches NUM_EXP while still in RUN; the guard keeps the read in range.
    always_comb begin
        w_exp_entry = '0;
        if (32'(r_store_count) < NUM_EXP) begin
            w_exp_entry = r_table[r_store_count[IW-1:0]];
        end
    end

    assign w_hit = (w_exp_entry == {aluout, writedata});

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_exp_cnt_nxt     = r_exp_cnt;
        w_store_count_nxt = r_store_count;
        w_cyc_nxt         = r_cyc;
        w_timeout_nxt     = r_timeout;
        w_err_addr_nxt    = r_err_addr;
        w_err_data_nxt    = r_err_data;

        if (start) begin
            // Start from any state (including RUN) begins a fresh run; a same-cycle store is dropped.
            w_state_nxt       = S_RUN;
            w_exp_cnt_nxt     = w_cnt_clamped;
            w_store_count_nxt = '0;
            w_cyc_nxt         = '0;
            w_timeout_nxt     = 1'b0;
            w_err_addr_nxt    = '0;
            w_err_data_nxt    = '0;
        end else if (r_state == S_RUN) begin
            if (r_cyc != CYC_MAX) begin
                w_cyc_nxt = r_cyc + TW'(1);
            end

            if (r_exp_cnt == '0) begin
                w_state_nxt = S_PASS;
            end else if (memwrite) begin
                if (w_hit) begin
                    w_store_count_nxt = w_count_inc;
                    if (w_count_inc == r_exp_cnt) begin
                        w_state_nxt = S_PASS;
                    end
                end else begin
                    w_state_nxt    = S_FAIL;
                    w_timeout_nxt  = 1'b0;
                    w_err_addr_nxt = aluout;
                    w_err_data_nxt = writedata;
                end
            end

            // A store decision in the last budget cycle wins over the timeout.
            if (w_state_nxt == S_RUN && r_cyc == CYC_LAST) begin
                w_state_nxt   = S_FAIL;
                w_timeout_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_exp_cnt     <= '0;
            r_store_count <= '0;
            r_cyc         <= '0;
            r_timeout     <= 1'b0;
            r_err_addr    <= '0;
            r_err_data    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_exp_cnt     <= w_exp_cnt_nxt;
            r_store_count <= w_store_count_nxt;
            r_cyc         <= w_cyc_nxt;
            r_timeout     <= w_timeout_nxt;
            r_err_addr    <= w_err_addr_nxt;
            r_err_data    <= w_err_data_nxt;
        end
    end

    // NOTE: the table is reset on purpose; a run started without reloading must see all-zero entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                r_table[i] <= '0;
            end
        end else if (exp_we && r_state != S_RUN && 32'(exp_idx) < NUM_EXP) begin
            r_table[exp_idx] <= {exp_addr, exp_data};
        end
    end

    assign busy        = (r_state == S_RUN);
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign timeout     = r_timeout;
    assign store_count = r_store_count;
    assign err_addr    = r_err_addr;
    assign err_data    = r_err_data;

endmodule

// File: tb/tb_mips_store_checker.sv
// Scoreboard bench for mips_store_checker: stimulus queues the expected end-of-run
// result and cycle; a monitor compares whenever a run finishes.
module tb_mips_store_checker;

    localparam int NUM_EXP = 8;
    localparam int TO_CYC  = 20;
    localparam int IW      = 3;
    localparam int CW      = 4;

    typedef struct {
        logic          pass;
        logic          fail;
        logic          tmo;
        logic [CW-1:0] sc;
        logic [31:0]   ea;
        logic [31:0]   ed;
        int            at;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    logic [31:0]   exp_addr;
    logic [31:0]   exp_data;
    logic [CW-1:0] exp_count;
    logic          start;
    logic          memwrite;
    logic [31:0]   aluout;
    logic [31:0]   writedata;
    logic          busy;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [CW-1:0] store_count;
    logic [31:0]   err_addr;
    logic [31:0]   err_data;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   run_c;

    mips_store_checker #(.NUM_EXP(NUM_EXP), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_count(exp_count), .start(start),
        .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
        .store_count(store_count), .err_addr(err_addr), .err_data(err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IW-1:0] idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d;
        step();
        exp_we = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        exp_count = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; aluout = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic expect_res(input logic p, input logic f, input logic t, input logic [CW-1:0] sc,
                              input logic [31:0] ea, input logic [31:0] ed, input int at);
        exp_t e;
        e.pass = p; e.fail = f; e.tmo = t; e.sc = sc; e.ea = ea; e.ed = ed; e.at = at;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check({name, "_drain"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Monitor: a run has finished when busy was high last sample and pass/fail is now set.
    initial begin
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && busy_prev && (pass || fail)) begin
                if (q.size() == 0) begin
                    check("unexpected_result", {62'd0, pass, fail}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("res_cycle",   64'(cyc),         64'(e.at));
                    check("res_pass",    64'(pass),        64'(e.pass));
                    check("res_fail",    64'(fail),        64'(e.fail));
                    check("res_timeout", 64'(timeout),     64'(e.tmo));
                    check("res_count",   64'(store_count), 64'(e.sc));
                    check("res_eaddr",   64'(err_addr),    64'(e.ea));
                    check("res_edata",   64'(err_data),    64'(e.ed));
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        reset = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        exp_count = '0; start = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0;

        #3;
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_pass",  64'(pass),        64'd0);
        check("rst_fail",  64'(fail),        64'd0);
        check("rst_tmo",   64'(timeout),     64'd0);
        check("rst_count", 64'(store_count), 64'd0);
        check("rst_eaddr", 64'(err_addr),    64'd0);
        check("rst_edata", 64'(err_data),    64'd0);
        step(); step();
        reset = 1'b1;
        step();

        // Single matching store
        load(3'd0, 32'h54, 32'd7);
        do_start(4'd1);
        expect_res(1, 0, 0, 4'd1, 32'h0, 32'h0, cyc + 1);
        do_store(32'h54, 32'd7);
        drain("match1");

        // Single mismatching store
        do_start(4'd1);
        expect_res(0, 1, 0, 4'd0, 32'h54, 32'd8, cyc + 1);
        do_store(32'h54, 32'd8);
        drain("mismatch1");

        // Three in-order stores with idle gaps
        load(3'd0, 32'h0, 32'd1);
        load(3'd1, 32'h4, 32'd2);
        load(3'd2, 32'h8, 32'd3);
        do_start(4'd3);
        do_store(32'h0, 32'd1);
        step();
        check("three_busy1", 64'(busy), 64'd1);
        do_store(32'h4, 32'd2);
        step();
        check("three_busy2", 64'(busy), 64'd1);
        check("three_pass2", 64'(pass), 64'd0);
        check("three_cnt2",  64'(store_count), 64'd2);
        expect_res(1, 0, 0, 4'd3, 32'h0, 32'h0, cyc + 1);
        do_store(32'h8, 32'd3);
        drain("three");

        // Timeout with no stores: FAIL exactly TO_CYC cycles after RUN entry
        load(3'd0, 32'h100, 32'd9);
        do_start(4'd1);
        run_c = cyc;
        expect_res(0, 1, 1, 4'd0, 32'h0, 32'h0, run_c + TO_CYC);
        drain("timeout");

        // Final matching store in the timeout cycle
        do_start(4'd1);
        run_c = cyc;
        repeat (TO_CYC - 1) step();
        expect_res(1, 0, 0, 4'd1, 32'h0, 32'h0, run_c + TO_CYC);
        do_store(32'h100, 32'd9);
        drain("to_match");

        // Mismatching store in the timeout cycle
        do_start(4'd1);
        run_c = cyc;
        repeat (TO_CYC - 1) step();
        expect_res(0, 1, 0, 4'd0, 32'h100, 32'd10, run_c + TO_CYC);
        do_store(32'h100, 32'd10);
        drain("to_mismatch");

        // Reset mid-run clears the table
        load(3'd0, 32'h54, 32'd7);
        load(3'd1, 32'h58, 32'd8);
        do_start(4'd2);
        do_store(32'h54, 32'd7);
        check("mid_count", 64'(store_count), 64'd1);
        reset = 1'b0;
        #2;
        check("mid_rst_busy",  64'(busy),        64'd0);
        check("mid_rst_count", 64'(store_count), 64'd0);
        step(); step();
        reset = 1'b1;
        step();
        check("post_rst_pass", 64'(pass), 64'd0);
        check("post_rst_fail", 64'(fail), 64'd0);
        do_start(4'd1);
        expect_res(0, 1, 0, 4'd0, 32'h54, 32'd7, cyc + 1);
        do_store(32'h54, 32'd7);
        drain("cleared_table");

        // Zero count passes on the first RUN edge
        expect_res(1, 0, 0, 4'd0, 32'h0, 32'h0, cyc + 2);
        do_start(4'd0);
        drain("zero_count");

        // Table write during RUN is ignored
        load(3'd0, 32'h54, 32'd7);
        do_start(4'd1);
        exp_we = 1'b1; exp_idx = 3'd0; exp_addr = 32'h99; exp_data = 32'd5;
        step();
        exp_we = 1'b0;
        expect_res(1, 0, 0, 4'd1, 32'h0, 32'h0, cyc + 1);
        do_store(32'h54, 32'd7);
        drain("we_in_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
